// File: rtl/sequenciador_estados_if.sv
// Handshake bundle between the control FSM / timer side and the timed-state sequencer.
// master: the environment (controller plus timer); slave: the sequencer itself.
interface sequenciador_estados_if #(
  parameter int unsigned STATE_W = 2
);
  logic               start;
  logic               abort;
  logic               loop_en;
  logic               next_state;
  logic               activate;
  logic [STATE_W-1:0] state;
  logic               busy;
  logic               step_pulse;
  logic               done;

  modport master (
    output start,
    output abort,
    output loop_en,
    output next_state,
    input  activate,
    input  state,
    input  busy,
    input  step_pulse,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    input  loop_en,
    input  next_state,
    output activate,
    output state,
    output busy,
    output step_pulse,
    output done
  );
endinterface

// File: rtl/sequenciador_estados.sv
// Timed-state sequencer: holds activate high until the pulse timer reports an elapsed
// interval, then drops activate for two cycles so the timer clears, and advances the step.
// Every output is a register; the comb processes compute their next values.
module sequenciador_estados #(
  parameter int unsigned NUM_STATES = 4,
  parameter int unsigned STATE_W    = 2
) (
  input logic                   i_clock,
  input logic                   i_reset_n,
  sequenciador_estados_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StArm, StRelease, StDone} fsm_e;

  localparam logic [STATE_W-1:0] LastStep = STATE_W'(NUM_STATES - 1);

  fsm_e               r_fsm;
  logic [STATE_W-1:0] r_state;
  logic               r_activate;
  logic               r_busy;
  logic               r_step_pulse;
  logic               r_done;
  logic               r_arm_first;  // high during the first ARM cycle after entry
  logic               r_rel_cnt;    // 0 on the first RELEASE cycle, 1 on the second

  fsm_e               w_fsm_d;
  logic [STATE_W-1:0] w_state_d;
  logic               w_activate_d;
  logic               w_busy_d;
  logic               w_step_pulse_d;
  logic               w_done_d;
  logic               w_arm_first_d;
  logic               w_rel_cnt_d;
  logic               w_ns_hit;
  logic               w_last;

  // A qualified timer indication: ARM, past the settle cycle.
  assign w_ns_hit = (r_fsm == StArm) && !r_arm_first && io_bus.next_state;
  assign w_last   = (r_state >= LastStep);

  // State register: FSM plus every registered output, synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_fsm        <= StIdle;
      r_state      <= '0;
      r_activate   <= 1'b0;
      r_busy       <= 1'b0;
      r_step_pulse <= 1'b0;
      r_done       <= 1'b0;
      r_arm_first  <= 1'b0;
      r_rel_cnt    <= 1'b0;
    end else begin
      r_fsm        <= w_fsm_d;
      r_state      <= w_state_d;
      r_activate   <= w_activate_d;
      r_busy       <= w_busy_d;
      r_step_pulse <= w_step_pulse_d;
      r_done       <= w_done_d;
      r_arm_first  <= w_arm_first_d;
      r_rel_cnt    <= w_rel_cnt_d;
    end
  end

  // Next-state logic; abort overrides everything, including a simultaneous next_state.
  always_comb begin
    w_fsm_d = r_fsm;
    if (io_bus.abort) begin
      w_fsm_d = StIdle;
    end else begin
      unique case (r_fsm)
        StIdle:    if (io_bus.start) w_fsm_d = StArm;
        StArm: begin
          if (w_ns_hit) begin
            w_fsm_d = (w_last && !io_bus.loop_en) ? StDone : StRelease;
          end
        end
        StRelease: if (r_rel_cnt) w_fsm_d = StArm;
        StDone:    w_fsm_d = StIdle;
        default:   w_fsm_d = StIdle;
      endcase
    end
  end

  // Output logic: next values of the registered outputs, derived from the next FSM state.
  always_comb begin
    w_activate_d   = (w_fsm_d == StArm);
    w_busy_d       = (w_fsm_d != StIdle);
    w_done_d       = (w_fsm_d == StDone);
    w_step_pulse_d = w_ns_hit && !io_bus.abort;
    w_arm_first_d  = (r_fsm != StArm);
    w_rel_cnt_d    = (r_fsm == StRelease) && (w_fsm_d == StRelease);
    w_state_d      = r_state;
    if (w_fsm_d == StIdle) begin
      w_state_d = '0;
    end else if (w_step_pulse_d) begin
      // Last step holds its index into DONE; otherwise wrap or increment.
      if (w_last) begin
        w_state_d = io_bus.loop_en ? '0 : LastStep;
      end else begin
        w_state_d = r_state + STATE_W'(1);
      end
    end
  end

  assign io_bus.activate   = r_activate;
  assign io_bus.state      = r_state;
  assign io_bus.busy       = r_busy;
  assign io_bus.step_pulse = r_step_pulse;
  assign io_bus.done       = r_done;

endmodule

// File: tb/tb_sequenciador_estados.sv
// Bench for sequenciador_estados: a per-cycle vector table with an output scoreboard,
// then timer-driven sequences (full run, loop, abort, mid-sequence reset).
module tb_sequenciador_estados;

  localparam int TC         = 10;          // timer terminal count
  localparam int FIRST_LAT  = TC + 2;      // start edge -> first step_pulse, in edges
  localparam int PERIOD     = TC + 4;      // interval + response + 2 release + 1 ignore
  localparam int NV         = 27;

  logic clk = 1'b0;
  logic reset_n;
  logic use_timer;
  logic ns_drive;
  int   tmr_cnt = 0;
  logic tmr_ns  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       loop_en;
    logic       ns;
    logic [5:0] exp;   // {activate, state[1:0], busy, step_pulse, done}
  } vec_t;

  vec_t       vecs [NV];
  logic [5:0] sb_q [$];
  int         st_q [$];

  sequenciador_estados_if #(.STATE_W(2)) u_if ();

  sequenciador_estados #(
    .NUM_STATES(4),
    .STATE_W   (2)
  ) u_dut (
    .i_clock  (clk),
    .i_reset_n(reset_n),
    .io_bus   (u_if)
  );

  always #10 clk = ~clk;

  // Timer model: counts while activate is high, raises next_state one cycle after TC.
  always @(posedge clk) begin
    if (!u_if.activate) begin
      tmr_cnt <= 0;
      tmr_ns  <= 1'b0;
    end else begin
      if (tmr_cnt < TC) tmr_cnt <= tmr_cnt + 1;
      tmr_ns <= (tmr_cnt >= TC);
    end
  end

  assign u_if.next_state = use_timer ? tmr_ns : ns_drive;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a timer-driven sequence from its start edge until busy falls (bounded).
  task automatic run_seq(input string tag, input int drop_after, input int exp_pulses);
    int n_pulse = 0;
    int n_done  = 0;
    int cyc     = 0;
    int last    = 0;
    int low_run = 0;
    int exp_st;
    tick();
    u_if.start = 1'b0;
    while (u_if.busy && cyc < 400) begin
      tick();
      cyc++;
      if (u_if.step_pulse) begin
        n_pulse++;
        exp_st = (st_q.size() != 0) ? st_q.pop_front() : -1;
        check({tag, "_step_state"}, 32'(u_if.state), exp_st);
        if (n_pulse == 1) check({tag, "_first_lat"}, cyc, FIRST_LAT);
        else              check({tag, "_period"}, cyc - last, PERIOD);
        last = cyc;
        if (n_pulse == drop_after) u_if.loop_en = 1'b0;
      end
      if (u_if.done) begin
        n_done++;
        check({tag, "_done_with_pulse"}, 32'(u_if.step_pulse), 1);
      end
      if (u_if.busy && !u_if.activate) begin
        low_run++;
      end else begin
        if (u_if.activate && low_run != 0) check({tag, "_release_len"}, low_run, 2);
        low_run = 0;
      end
    end
    check({tag, "_pulses"}, n_pulse, exp_pulses);
    check({tag, "_done_cnt"}, n_done, 1);
    check({tag, "_busy_low"}, 32'(u_if.busy), 0);
    check({tag, "_busy_fall"}, cyc - last, 1);
    check({tag, "_sb_empty"}, st_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] got;
    logic [5:0] exp;
    int         n;

    //            rst st ab lp ns   act st busy sp done
    vecs[0]  = '{0, 1, 0, 0, 0, 6'b0_00_0_0_0};
    vecs[1]  = '{0, 1, 0, 0, 0, 6'b0_00_0_0_0};
    vecs[2]  = '{0, 1, 0, 0, 0, 6'b0_00_0_0_0};
    vecs[3]  = '{1, 0, 0, 0, 0, 6'b0_00_0_0_0};
    vecs[4]  = '{1, 1, 1, 0, 0, 6'b0_00_0_0_0};  // abort beats start
    vecs[5]  = '{1, 1, 0, 0, 0, 6'b1_00_1_0_0};
    vecs[6]  = '{1, 0, 0, 0, 1, 6'b1_00_1_0_0};  // first ARM cycle ignores next_state
    vecs[7]  = '{1, 0, 0, 0, 1, 6'b0_01_1_1_0};
    vecs[8]  = '{1, 1, 0, 0, 1, 6'b0_01_1_0_0};  // RELEASE ignores next_state and start
    vecs[9]  = '{1, 0, 0, 0, 1, 6'b1_01_1_0_0};
    vecs[10] = '{1, 0, 0, 0, 1, 6'b1_01_1_0_0};
    vecs[11] = '{1, 1, 0, 0, 0, 6'b1_01_1_0_0};  // start in ARM ignored
    vecs[12] = '{1, 0, 0, 0, 1, 6'b0_10_1_1_0};
    vecs[13] = '{1, 0, 0, 0, 0, 6'b0_10_1_0_0};
    vecs[14] = '{1, 0, 0, 0, 0, 6'b1_10_1_0_0};
    vecs[15] = '{1, 0, 0, 0, 0, 6'b1_10_1_0_0};
    vecs[16] = '{1, 0, 0, 0, 1, 6'b0_11_1_1_0};
    vecs[17] = '{1, 0, 0, 0, 0, 6'b0_11_1_0_0};
    vecs[18] = '{1, 0, 0, 0, 0, 6'b1_11_1_0_0};
    vecs[19] = '{1, 0, 0, 0, 1, 6'b1_11_1_0_0};
    vecs[20] = '{1, 0, 0, 0, 1, 6'b0_11_1_1_1};  // last step, no loop -> DONE
    vecs[21] = '{1, 1, 0, 0, 0, 6'b0_00_0_0_0};
    vecs[22] = '{1, 0, 0, 0, 0, 6'b0_00_0_0_0};
    vecs[23] = '{1, 1, 0, 0, 0, 6'b1_00_1_0_0};
    vecs[24] = '{1, 0, 0, 0, 0, 6'b1_00_1_0_0};
    vecs[25] = '{1, 0, 1, 0, 1, 6'b0_00_0_0_0};  // abort with next_state: no pulse
    vecs[26] = '{1, 0, 0, 0, 0, 6'b0_00_0_0_0};

    use_timer    = 1'b0;
    ns_drive     = 1'b0;
    reset_n      = 1'b0;
    u_if.start   = 1'b0;
    u_if.abort   = 1'b0;
    u_if.loop_en = 1'b0;

    for (int i = 0; i < NV; i++) begin
      reset_n      = vecs[i].rst_n;
      u_if.start   = vecs[i].start;
      u_if.abort   = vecs[i].abort;
      u_if.loop_en = vecs[i].loop_en;
      ns_drive     = vecs[i].ns;
      sb_q.push_back(vecs[i].exp);
      tick();
      got = {u_if.activate, u_if.state, u_if.busy, u_if.step_pulse, u_if.done};
      exp = sb_q.pop_front();
      check($sformatf("vec%0d", i), 32'(got), 32'(exp));
    end
    u_if.start = 1'b0;
    u_if.abort = 1'b0;
    ns_drive   = 1'b0;
    use_timer  = 1'b1;
    tick();

    // Full non-looping sequence with the timer model.
    u_if.loop_en = 1'b0;
    st_q = '{1, 2, 3, 3};
    u_if.start = 1'b1;
    run_seq("full", 0, 4);
    tick();

    // Looping: wraps to 0 after step 3, loop_en dropped during the second pass.
    u_if.loop_en = 1'b1;
    st_q = '{1, 2, 3, 0, 1, 2, 3, 3};
    u_if.start = 1'b1;
    run_seq("loop", 5, 8);
    tick();

    // Abort in ARM of step 2 while the timer reports next_state.
    u_if.loop_en = 1'b0;
    u_if.start   = 1'b1;
    tick();
    u_if.start = 1'b0;
    n = 0;
    while (!(u_if.state == 2'd2 && u_if.activate && u_if.next_state) && n < 200) begin
      tick();
      n++;
    end
    check("abort_reach", 32'(n < 200), 1);
    u_if.abort = 1'b1;
    tick();
    u_if.abort = 1'b0;
    check("abort_pulse", 32'(u_if.step_pulse), 0);
    check("abort_state", 32'(u_if.state), 0);
    check("abort_act", 32'(u_if.activate), 0);
    check("abort_busy", 32'(u_if.busy), 0);
    check("abort_done", 32'(u_if.done), 0);
    tick();
    check("abort_tmr_cnt", tmr_cnt, 0);
    check("abort_tmr_ns", 32'(u_if.next_state), 0);
    check("abort_idle", 32'(u_if.busy), 0);

    // Mid-sequence reset during step 1, then a clean restart.
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    n = 0;
    while (u_if.state != 2'd1 && n < 200) begin
      tick();
      n++;
    end
    check("mrst_reach", 32'(n < 200), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    got = {u_if.activate, u_if.state, u_if.busy, u_if.step_pulse, u_if.done};
    check("mrst_outputs", 32'(got), 0);
    st_q = '{1, 2, 3, 3};
    u_if.start = 1'b1;
    run_seq("mrst", 0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequenciador_estados.md
# sequenciador_estados

Timed-state sequencer driving the 4 s pulse timer from the controller side. Raises `activate`, waits for the timer's `next_state` indication, drops `activate` long enough for the timer to clear its counter, then advances to the next step. Sits between the top-level control FSM, which issues `start` and `abort`, and the timer instance. Each step index drives downstream display/output selection.

## Interface
- `NUM_STATES`, 4: number of timed steps per sequence, ≥2.
- `STATE_W`, 2: width of `state`, ≥ clog2(`NUM_STATES`).

- `clock`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `abort`  in  1  cancel the current sequence; has priority over all other inputs.
- `loop_en`  in  1  1 = wrap to step 0 after the last step; 0 = finish.
- `next_state`  in  1  from the timer; high once the timer interval has elapsed while `activate` is held.
- `activate`  out  1  to the timer; high = count.
- `state`  out  STATE_W  current step index.
- `busy`  out  1  high in every FSM state except IDLE.
- `step_pulse`  out  1  one-cycle strobe on each elapsed interval.
- `done`  out  1  one-cycle strobe when a non-looping sequence completes.

## Operation
- FSM states: IDLE, ARM, RELEASE, DONE. All outputs are registered.
- IDLE: `activate`=0, `state`=0. On `start`=1 and `abort`=0, go to ARM.
- ARM: `activate`=1. `next_state` is ignored in the first ARM cycle after entry. After that, `next_state`=1 does the following:
  - Pulse `step_pulse`.
  - If `state` < NUM_STATES-1: increment `state` and go to RELEASE.
  - If `state` = NUM_STATES-1 and `loop_en`=1: set `state`=0 and go to RELEASE.
  - If `state` = NUM_STATES-1 and `loop_en`=0: go to DONE.
- RELEASE: `activate`=0 for exactly 2 cycles, then go to ARM. `next_state` is ignored throughout. This guarantees the timer sees `activate` low, clears its counter, and drops `next_state`.
- DONE: `activate`=0. Pulse `done` for one cycle, then go to IDLE. `state` holds NUM_STATES-1 during the DONE cycle, then returns to 0.
- `abort`=1 in any state: on the next edge go to IDLE with `activate`=0, `state`=0, and `step_pulse`=`done`=0, even if `next_state` is also high.
- `start` while `busy`=1 is ignored. `start` and `abort` in the same cycle: `abort` wins.
- `loop_en` is sampled only at the last-step decision.
- `state` arithmetic is modulo NUM_STATES and never exceeds NUM_STATES-1.

## Timing
- Reset (`reset_n`=0 at an edge): IDLE; `activate`=0, `state`=0, `busy`=0, `step_pulse`=0, `done`=0. Reset mid-sequence behaves identically to reset from IDLE, and the timer clears because `activate` falls.
- `start` high at edge t: `activate`=1 and `busy`=1 from t+1.
- `next_state` high sampled at edge t (ARM, not the first cycle): `step_pulse` and the new `state` appear at t+1; `activate`=0 during t+1 and t+2; `activate`=1 again at t+3.
- Step period = timer interval + 1 timer response cycle + 2 RELEASE cycles + 1 ARM ignore cycle. The extra overhead is constant and deterministic.
- Last step with `loop_en`=0: `done` is high at t+1 and `busy` falls at t+2.
- `abort` at edge t: `activate`=0 and `busy`=0 at t+1.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles while `start`=1 → all outputs 0 and FSM in IDLE after release.
- Full sequence: timer model with terminal count 10, NUM_STATES=4, `loop_en`=0, `start` pulse → 4 `step_pulse` strobes, `state` sequence 1,2,3, one `done` pulse, `busy` low afterwards, `activate` low for exactly 2 cycles between steps.
- Loop: `loop_en`=1 → after step 3, `state` returns to 0 and `activate` re-arms. Drop `loop_en` during the second pass → `done` after that pass's step 3.
- Abort: assert `abort` in ARM of step 2 together with `next_state`=1 → no `step_pulse`, `state`=0, `activate`=0 next cycle, and the timer counter clears.
- Ignored inputs: `start` pulses during ARM and RELEASE, and `next_state` forced high throughout RELEASE → no restart and no extra `step_pulse`.
- Mid-sequence reset: `reset_n`=0 for 1 cycle during step 1 → outputs reset. A new `start` runs a clean sequence with the full timer interval on step 0.
